// File: rtl/seq_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_stream_gen
// Brief    : Serial MSB-first bit-stream transmitter feeding the Mealy
//            sequence detector. Optional inter-frame gap: SEQ_GEN_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_stream_gen #(
    parameter int   DATA_W   = 16,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0,
    parameter int   GAP_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [$clog2(DATA_W+1)-1:0]   nbits,
    input  logic [CNT_W-1:0]              repeats,
    output logic                          ready,
    output logic                          x,
    output logic                          x_valid,
    output logic                          frame_start,
    output logic                          done
);

    localparam int c_NB_W = $clog2(DATA_W + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

`ifdef SEQ_GEN_GAP_EN
    localparam logic [1:0] c_S_GAP   = 2'd3;
    localparam int         c_GAP_W   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam bit         c_GAP_EN  = 1'b1;
`else
    localparam bit         c_GAP_EN  = 1'b0;
`endif
    // A zero-length gap collapses to the back-to-back behaviour.
    localparam bit c_GAP_ACTIVE = c_GAP_EN && (GAP_BITS > 0);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_shift;
    logic [c_NB_W-1:0] r_effn;
    logic [c_NB_W-1:0] r_bitcnt;
    logic [CNT_W-1:0]  r_rep;
    logic [CNT_W-1:0]  r_frame;
    logic              r_ready;
    logic              r_x;
    logic              r_x_valid;
    logic              r_frame_start;
    logic              r_done;
`ifdef SEQ_GEN_GAP_EN
    logic [c_GAP_W-1:0] r_gapcnt;
`endif

    logic [c_NB_W-1:0] w_eff_n;
    logic [c_NB_W-1:0] w_shamt;
    logic [DATA_W-1:0] w_aligned;
    logic              w_last_bit;
    logic              w_last_frame;

    // Left-align the pattern so every frame is simply shifted out of the MSB.
    assign w_eff_n      = (nbits > c_NB_W'(DATA_W)) ? c_NB_W'(DATA_W) : nbits;
    assign w_shamt      = c_NB_W'(DATA_W) - w_eff_n;
    assign w_aligned    = data_in << w_shamt;
    assign w_last_bit   = (r_bitcnt == (r_effn - c_NB_W'(1)));
    // Compare before incrementing so repeats = all-ones never wraps early.
    assign w_last_frame = (r_frame == r_rep);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_S_IDLE;
            r_data        <= '0;
            r_shift       <= '0;
            r_effn        <= '0;
            r_bitcnt      <= '0;
            r_rep         <= '0;
            r_frame       <= '0;
            r_ready       <= 1'b1;
            r_x           <= IDLE_BIT;
            r_x_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            r_gapcnt      <= '0;
`endif
        end else begin
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_ready  <= 1'b0;
                        r_data   <= w_aligned;
                        r_effn   <= w_eff_n;
                        r_rep    <= repeats;
                        r_frame  <= '0;
                        r_bitcnt <= '0;
                        if (w_eff_n == '0) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= c_S_SHIFT;
                            r_x           <= w_aligned[DATA_W-1];
                            r_shift       <= w_aligned << 1;
                            r_x_valid     <= 1'b1;
                            r_frame_start <= 1'b1;
                        end
                    end
                end

                c_S_SHIFT: begin
                    if (w_last_bit) begin
                        if (w_last_frame) begin
                            r_state   <= c_S_DONE;
                            r_done    <= 1'b1;
                            r_x       <= IDLE_BIT;
                            r_x_valid <= 1'b0;
                        end else begin
                            r_frame  <= r_frame + CNT_W'(1);
                            r_bitcnt <= '0;
                            if (c_GAP_ACTIVE) begin
`ifdef SEQ_GEN_GAP_EN
                                r_state  <= c_S_GAP;
                                r_gapcnt <= '0;
`endif
                                r_x       <= IDLE_BIT;
                                r_x_valid <= 1'b0;
                            end else begin
                                r_x           <= r_data[DATA_W-1];
                                r_shift       <= r_data << 1;
                                r_frame_start <= 1'b1;
                            end
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + c_NB_W'(1);
                        r_x      <= r_shift[DATA_W-1];
                        r_shift  <= r_shift << 1;
                    end
                end

`ifdef SEQ_GEN_GAP_EN
                c_S_GAP: begin
                    if (r_gapcnt == c_GAP_W'(GAP_BITS - 1)) begin
                        r_state       <= c_S_SHIFT;
                        r_x           <= r_data[DATA_W-1];
                        r_shift       <= r_data << 1;
                        r_x_valid     <= 1'b1;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_gapcnt <= r_gapcnt + c_GAP_W'(1);
                    end
                end
`endif

                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign x           = r_x;
    assign x_valid     = r_x_valid;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_stream_gen
// Brief    : Directed, table-driven self-checking bench for seq_stream_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stream_gen;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  nbits;
        logic [7:0]  reps;
        logic [63:0] ex;    // expected x, cycle c at bit [64-c]
        logic [63:0] ev;    // expected x_valid
        logic [63:0] efs;   // expected frame_start
        int          edone; // cycle holding the done pulse
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [4:0]  nbits = '0;
    logic [7:0]  repeats = '0;
    logic        ready, x, x_valid, frame_start, done;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    seq_stream_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .nbits       (nbits),
        .repeats     (repeats),
        .ready       (ready),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [15:0] d, input logic [4:0] n, input logic [7:0] r,
                                input logic [63:0] ex, input logic [63:0] ev,
                                input logic [63:0] efs, input int edone);
        vec_t v;
        v.data = d; v.nbits = n; v.reps = r;
        v.ex = ex; v.ev = ev; v.efs = efs; v.edone = edone;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the DUT outputs of transfer cycle c against the bit masks.
    task automatic observe(input string tag, input int c, input logic [63:0] ex,
                           input logic [63:0] ev, input logic [63:0] efs, input logic [63:0] ed);
        check($sformatf("%s c%0d x", tag, c), 64'(x), 64'(ex[64-c]));
        check($sformatf("%s c%0d x_valid", tag, c), 64'(x_valid), 64'(ev[64-c]));
        check($sformatf("%s c%0d frame_start", tag, c), 64'(frame_start), 64'(efs[64-c]));
        check($sformatf("%s c%0d done", tag, c), 64'(done), 64'(ed[64-c]));
    endtask

    task automatic launch(input logic [15:0] d, input logic [4:0] n, input logic [7:0] r);
        @(negedge clk);
        check("ready before start", 64'(ready), 64'd1);
        data_in = d; nbits = n; repeats = r; start = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [63:0] ed;
        v  = vecs[idx];
        ed = 64'd1 << (64 - v.edone);
        launch(v.data, v.nbits, v.reps);
        for (int c = 1; c <= v.edone + 1; c++) begin
            @(negedge clk);
            observe($sformatf("vec%0d", idx), c, v.ex, v.ev, v.efs, ed);
            if (c == v.edone + 1)
                check($sformatf("vec%0d ready after done", idx), 64'(ready), 64'd1);
            if (c == 1) begin
                // Inputs scrambled mid-transfer must not disturb the stream.
                start = 1'b0; data_in = ~v.data; nbits = 5'd7; repeats = 8'd9;
            end
        end
    endtask

    initial begin
        vecs.push_back(mk(16'h000D, 5'd4,  8'd0,   64'hD000_0000_0000_0000, 64'hF000_0000_0000_0000, 64'h8000_0000_0000_0000, 5));
        vecs.push_back(mk(16'hFFFF, 5'd0,  8'd3,   64'h0,                   64'h0,                   64'h0,                   1));
        vecs.push_back(mk(16'hA5F0, 5'd20, 8'd0,   64'hA5F0_0000_0000_0000, 64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0000, 17));
`ifdef SEQ_GEN_GAP_EN
        vecs.push_back(mk(16'h000D, 5'd4,  8'd1,   64'hD340_0000_0000_0000, 64'hF3C0_0000_0000_0000, 64'h8200_0000_0000_0000, 11));
`else
        vecs.push_back(mk(16'h000D, 5'd4,  8'd2,   64'hDDD0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h8880_0000_0000_0000, 13));
        vecs.push_back(mk(16'h8001, 5'd16, 8'd1,   64'h8001_8001_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h8000_8000_0000_0000, 33));
        vecs.push_back(mk(16'hFFFE, 5'd1,  8'd3,   64'h0,                   64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000, 5));
        vecs.push_back(mk(16'h0005, 5'd3,  8'd1,   64'hB400_0000_0000_0000, 64'hFC00_0000_0000_0000, 64'h9000_0000_0000_0000, 7));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(ready), 64'd1);
        check("reset x", 64'(x), 64'd0);
        check("reset x_valid", 64'(x_valid), 64'd0);
        check("reset frame_start", 64'(frame_start), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // start while busy is ignored: one frame, one done.
        launch(16'h000D, 5'd4, 8'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            observe("busy", c, 64'hD000_0000_0000_0000, 64'hF000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000);
            if (c == 1) start = 1'b0;
            if (c == 2) begin start = 1'b1; data_in = 16'hFFFF; end
            if (c == 3) start = 1'b0;
        end

        // start held high: re-accepted in the first ready cycle after DONE.
        launch(16'h0002, 5'd2, 8'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            observe("hold", c, 64'h8800_0000_0000_0000, 64'hCC00_0000_0000_0000,
                    64'h8800_0000_0000_0000, 64'h2200_0000_0000_0000);
            if (c == 4) check("hold ready c4", 64'(ready), 64'd1);
            if (c == 5) start = 1'b0;
        end
        check("hold ready c8", 64'(ready), 64'd1);

        // Reset mid-transfer aborts without a done pulse.
        launch(16'h000D, 5'd4, 8'd0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("midrst c2 x_valid", 64'(x_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst x", 64'(x), 64'd0);
        check("midrst x_valid", 64'(x_valid), 64'd0);
        check("midrst ready", 64'(ready), 64'd1);
        reset = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("midrst c%0d done", c), 64'(done), 64'd0);
            check($sformatf("midrst c%0d x_valid", c), 64'(x_valid), 64'd0);
        end

        // reset and start together: reset wins, start dropped.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; data_in = 16'h000D; nbits = 5'd4; repeats = 8'd0;
        @(negedge clk);
        check("rst+start ready", 64'(ready), 64'd1);
        check("rst+start x_valid", 64'(x_valid), 64'd0);
        reset = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst+start idle x_valid", 64'(x_valid), 64'd0);
            check("rst+start idle done", 64'(done), 64'd0);
        end

        // Maximum repeats: 256 one-bit frames, counter must not wrap early.
        begin
            int nvalid = 0, nfs = 0, done_c = -1, exp_done = 257;
`ifdef SEQ_GEN_GAP_EN
            exp_done = 257 + 255 * 2;
`endif
            launch(16'h0001, 5'd1, 8'd255);
            for (int c = 1; c <= 900 && done_c < 0; c++) begin
                @(negedge clk);
                if (c == 1) start = 1'b0;
                if (x_valid) nvalid++;
                if (frame_start) nfs++;
                if (done) done_c = c;
            end
            check("maxrep valid bits", 64'(nvalid), 64'd256);
            check("maxrep frame_starts", 64'(nfs), 64'd256);
            check("maxrep done cycle", 64'(done_c), 64'(exp_done));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_stream_gen.md
Name: seq_stream_gen

Overview:
- Serial bit-stream transmitter: takes a parallel pattern, bit count and repeat count, and drives a single-bit stream `x`, one bit per clock, MSB-first.
- Sits upstream of the overlapping Mealy sequence detector: its `x`/`clk`/`reset` drive the detector's `x`/`clk`/`reset`.
- Used as the on-chip stimulus source for the detector, in place of hand-timed testbench waveforms.

Parameters:
- DATA_W, 16: width of the pattern register; maximum bits per frame.
- CNT_W, 8: width of the repeat counter.
- IDLE_BIT, 1'b0: value driven on `x` whenever no frame bit is being sent.
- GAP_BITS, 2: idle bits inserted between frames. Used only with SEQ_GEN_GAP_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer; sampled only while ready=1.
- data_in  in  DATA_W  pattern; bits [nbits-1:0] are sent, MSB-first.
- nbits  in  $clog2(DATA_W+1)  bits per frame.
- repeats  in  CNT_W  extra frames; total frames = repeats+1.
- ready  out  1  high in IDLE; a start is accepted only while high.
- x  out  1  serial output bit.
- x_valid  out  1  high when `x` carries a frame bit.
- frame_start  out  1  one-cycle pulse coincident with bit 0 of each frame.
- done  out  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- Reset values (cycle after reset is sampled high):
  - ready=1, x=IDLE_BIT, x_valid=0, frame_start=0, done=0; FSM in IDLE.
  - Shift register, bit counter and frame counter all cleared.
- States: IDLE, SHIFT, GAP (only with SEQ_GEN_GAP_EN), DONE.
- IDLE:
  - ready=1. When start=1, latch data_in, eff_n = min(nbits, DATA_W) and repeats.
  - If eff_n=0: go to DONE; no bits are sent.
  - Otherwise: go to SHIFT.
- SHIFT:
  - Latency: the first bit appears on `x` in the cycle after start is accepted.
  - Each cycle: x = data[eff_n-1-k] for k = 0..eff_n-1, x_valid=1, ready=0.
  - frame_start=1 when k=0.
  - After bit eff_n-1: if the frame counter equals the latched repeats, go to DONE. Otherwise increment the frame counter and restart at k=0 (GAP first if enabled). Consecutive frames are back-to-back with no idle cycle.
- DONE:
  - One cycle: done=1, ready=0, x=IDLE_BIT, x_valid=0. Then IDLE.
  - The earliest next accept is the cycle after DONE.
- Outputs are registered; `x` changes only on clock edges.
- Input changes:
  - start while ready=0 is ignored and not queued.
  - Changes to data_in, nbits or repeats during a transfer have no effect.
- Clamping:
  - nbits > DATA_W is clamped to DATA_W.
  - repeats = 2^CNT_W-1 yields 2^CNT_W frames; the frame counter must not wrap early.
- Reset mid-transfer: aborts immediately; no done pulse; all outputs return to reset values the next cycle.
- reset and start high together: reset wins and start is dropped.
- Total cycles from accept to done: (repeats+1)·eff_n + 1. With SEQ_GEN_GAP_EN, add repeats·GAP_BITS.

Optional Feature:
- SEQ_GEN_GAP_EN defined:
  - Between consecutive frames, the FSM spends GAP_BITS cycles in GAP.
  - During GAP: x=IDLE_BIT, x_valid=0, frame_start=0.
  - No gap after the last frame.
  - GAP_BITS=0 behaves as if the feature were undefined.
- SEQ_GEN_GAP_EN undefined: frames are back-to-back; the GAP state and its counter are not compiled.

Test Plan:
- Single frame: data_in=16'h000D, nbits=4, repeats=0, start pulsed at cycle 0 -> x=1,1,0,1 with x_valid=1 in cycles 1-4; frame_start in cycle 1; done in cycle 5; ready=1 in cycle 6. Feeding the detector yields its expected match.
- Repeats: data_in=16'h000D, nbits=4, repeats=2 -> 1101 1101 1101 in cycles 1-12; frame_start in cycles 1, 5, 9; done in cycle 13.
- Boundaries:
  - nbits=0 -> no x_valid; done in cycle 1.
  - nbits=20 with data_in=16'hA5F0 -> 16 bits 1010 0101 1111 0000; done in cycle 17.
- Busy/reset:
  - start pulsed in cycle 2 of a 4-bit transfer -> ignored; only one done.
  - reset asserted in cycle 2 -> from cycle 3: x=0, x_valid=0, ready=1; no done pulse.
- Gap (SEQ_GEN_GAP_EN, GAP_BITS=2): data_in=16'h000D, nbits=4, repeats=1 -> x=1101 00 1101; x_valid low in cycles 5-6; done in cycle 11.
